// File: rtl/branch_flow_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_flow_ctrl_pkg
//   Shared definitions for the branch predictor flow controller:
//     - flow_state_e : recovery FSM encoding (RUN / FLUSH / REFILL)
//     - PC_INC       : fall-through increment for a not-taken redirect
//     - UPD_PCW / upd_entry_t : update queue entry {pc, taken, target} at the
//       default 32-bit PC width.
//   The update FIFO defaults to upd_entry_t. The top re-declares the same
//   layout at its own PCW so that non-default widths stay consistent.
// -----------------------------------------------------------------------------
package branch_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } flow_state_e;

    localparam int unsigned PC_INC  = 4;
    localparam int unsigned UPD_PCW = 32;

    typedef struct packed {
        logic [UPD_PCW-1:0] pc;
        logic               taken;
        logic [UPD_PCW-1:0] target;
    } upd_entry_t;

endpackage

// File: rtl/branch_update_fifo.sv
// -----------------------------------------------------------------------------
// branch_update_fifo
//   Small FIFO that holds resolved-branch updates waiting for the predictor
//   table port. Pointers carry one extra wrap bit, so full and empty can be
//   told apart without a separate counter.
//   A push is accepted while full only when a pop happens in the same cycle.
//
// Parameters
//   entry_t : payload type
//   DEPTH   : number of entries (power of 2, >= 2)
//
// Ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to store
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (only meaningful when !empty_o)
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
// -----------------------------------------------------------------------------
module branch_update_fifo
    import branch_flow_ctrl_pkg::*;
#(
    parameter type         entry_t = upd_entry_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Same slot with different wrap bits means the writer is a full lap ahead.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define which slots are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_flow_ctrl.sv
// -----------------------------------------------------------------------------
// branch_flow_ctrl
//   Front-end controller for the branch predictor's single-ported
//   pattern/target table. Each cycle it grants the port to either an ID-stage
//   lookup or an EX-stage update. Updates wait in a small FIFO. The block also
//   detects EX mispredictions and sequences recovery: flush, PC redirect, then
//   a refill window during which lookups stay suppressed.
//
// Optional feature (macro BRANCH_FLOW_STATS_EN)
//   When defined, the block adds the BranchCount and MispredCount outputs.
//   These are saturating CNTW-bit counters of RUN-state EX branches and
//   RUN-state mispredicts.
//
// Handshake: the table port has no back-pressure. LookupReq or UpdateReq
//   high means the access happens this cycle. StallID high means the ID
//   branch was not serviced and ID must hold. An update is popped exactly on
//   the cycle UpdateReq is high.
//
// Ports
//   Clock, Reset                      : clock, async active-high reset
//   BranchExists_ID, PCNow_ID         : ID-stage branch lookup request
//   BranchExists_EX, PCNow_EX,
//   BranchDecision_EX, BranchTarget_EX,
//   Predicted_EX, PredTarget_EX       : EX-stage resolution + carried prediction
//   LookupReq, LookupPC               : table lookup strobe and address
//                                       (address is 0 when no lookup)
//   UpdateReq, UpdatePC, UpdateTaken,
//   UpdateTarget                      : table update strobe and payload (queue
//                                       head; payload is 0 when no update)
//   StallID                           : ID must hold, lookup not serviced
//   FlushIFID, FlushIDEX, Redirect    : one-cycle recovery pulses
//   RedirectPC                        : recovery fetch address
//   DbgState                          : current recovery FSM state
// -----------------------------------------------------------------------------
module branch_flow_ctrl
    import branch_flow_ctrl_pkg::*;
#(
    parameter int unsigned PCW           = 32,
    parameter int unsigned QDEPTH        = 2,
    parameter int unsigned REFILL_CYCLES = 2
`ifdef BRANCH_FLOW_STATS_EN
    ,
    parameter int unsigned CNTW          = 16
`endif
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              BranchExists_ID,
    input  logic [PCW-1:0]    PCNow_ID,
    input  logic              BranchExists_EX,
    input  logic [PCW-1:0]    PCNow_EX,
    input  logic              BranchDecision_EX,
    input  logic [PCW-1:0]    BranchTarget_EX,
    input  logic              Predicted_EX,
    input  logic [PCW-1:0]    PredTarget_EX,
    output logic              LookupReq,
    output logic [PCW-1:0]    LookupPC,
    output logic              UpdateReq,
    output logic [PCW-1:0]    UpdatePC,
    output logic              UpdateTaken,
    output logic [PCW-1:0]    UpdateTarget,
    output logic              StallID,
    output logic              FlushIFID,
    output logic              FlushIDEX,
    output logic              Redirect,
    output logic [PCW-1:0]    RedirectPC,
`ifdef BRANCH_FLOW_STATS_EN
    output logic [CNTW-1:0]   BranchCount,
    output logic [CNTW-1:0]   MispredCount,
`endif
    output flow_state_e       DbgState
);

    // Counter only needs to hold REFILL_CYCLES-1.
    localparam int unsigned CW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
        logic [PCW-1:0] target;
    } entry_t;

    flow_state_e    state_q, state_d;
    logic [CW-1:0]  refill_cnt_q, refill_cnt_d;
    logic [PCW-1:0] redirect_pc_q, redirect_pc_d;

    entry_t push_entry;
    entry_t head_entry;
    logic   q_full;
    logic   q_empty;
    logic   mispredict;
    logic   lookup_en;
    logic   lookup_req;
    logic   update_req;
    logic   stall_id;
    logic   recover_pulse;

    // ------------------------------------------------------------------
    // Update queue: every resolved EX branch is queued, including
    // wrong-path ones seen during recovery.
    // ------------------------------------------------------------------
    assign push_entry.pc     = PCNow_EX;
    assign push_entry.taken  = BranchDecision_EX;
    assign push_entry.target = BranchTarget_EX;

    branch_update_fifo #(
        .entry_t (entry_t),
        .DEPTH   (QDEPTH)
    ) u_update_fifo (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .push_i      (BranchExists_EX),
        .push_data_i (push_entry),
        .pop_i       (update_req),
        .head_o      (head_entry),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // A wrong target counts only on a taken branch; a not-taken branch
    // ignores the target field.
    assign mispredict = BranchExists_EX &&
                        ((BranchDecision_EX != Predicted_EX) ||
                         (BranchDecision_EX && (BranchTarget_EX != PredTarget_EX)));

    assign lookup_en = (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Port arbitration. A full queue wins so that next cycle's EX push can
    // never be dropped. ID stalls only in RUN; during recovery the ID
    // branch is wrong-path and is simply discarded.
    // ------------------------------------------------------------------
    always_comb begin
        lookup_req = 1'b0;
        update_req = 1'b0;
        stall_id   = 1'b0;
        if (q_full) begin
            update_req = 1'b1;
            stall_id   = BranchExists_ID && lookup_en;
        end else if (BranchExists_ID && lookup_en) begin
            lookup_req = 1'b1;
        end else if (!q_empty) begin
            update_req = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Recovery FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        refill_cnt_d  = refill_cnt_q;
        redirect_pc_d = redirect_pc_q;
        recover_pulse = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = BranchDecision_EX ? BranchTarget_EX
                                                      : PCNow_EX + PCW'(PC_INC);
                end
            end
            ST_FLUSH: begin
                recover_pulse = 1'b1;
                state_d       = ST_REFILL;
                refill_cnt_d  = CW'(REFILL_CYCLES - 1);
            end
            ST_REFILL: begin
                if (refill_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    refill_cnt_d = refill_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_RUN;
            refill_cnt_q  <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            refill_cnt_q  <= refill_cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign LookupReq    = lookup_req;
    assign LookupPC     = lookup_req ? PCNow_ID : '0;
    assign UpdateReq    = update_req;
    assign UpdatePC     = update_req ? head_entry.pc     : '0;
    assign UpdateTaken  = update_req ? head_entry.taken  : 1'b0;
    assign UpdateTarget = update_req ? head_entry.target : '0;
    assign StallID      = stall_id;
    assign FlushIFID    = recover_pulse;
    assign FlushIDEX    = recover_pulse;
    assign Redirect     = recover_pulse;
    assign RedirectPC   = redirect_pc_q;
    assign DbgState     = state_q;

`ifdef BRANCH_FLOW_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: right-path (RUN-state) EX branches only, saturating.
    // ------------------------------------------------------------------
    logic [CNTW-1:0] branch_cnt_q;
    logic [CNTW-1:0] mispred_cnt_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (BranchExists_EX && (branch_cnt_q != {CNTW{1'b1}})) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict && (mispred_cnt_q != {CNTW{1'b1}})) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Directed bench for branch_flow_ctrl (PCW=32, QDEPTH=2, REFILL_CYCLES=2).
// Update payloads and redirect addresses are hand-computed and pushed to
// expected queues; a negedge monitor pops and compares them whenever the DUT
// presents UpdateReq or Redirect. Control strobes are checked inline.
module tb_branch_flow_ctrl;
  import branch_flow_ctrl_pkg::*;

  localparam int PCW = 32;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  // ---------------- DUT signals ----------------
  logic           branch_exists_id;
  logic [PCW-1:0] pc_now_id;
  logic           branch_exists_ex;
  logic [PCW-1:0] pc_now_ex;
  logic           branch_decision_ex;
  logic [PCW-1:0] branch_target_ex;
  logic           predicted_ex;
  logic [PCW-1:0] pred_target_ex;
  logic           lookup_req;
  logic [PCW-1:0] lookup_pc;
  logic           update_req;
  logic [PCW-1:0] update_pc;
  logic           update_taken;
  logic [PCW-1:0] update_target;
  logic           stall_id;
  logic           flush_ifid;
  logic           flush_idex;
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
  flow_state_e    dbg_state;
`ifdef BRANCH_FLOW_STATS_EN
  logic [15:0]    branch_count;
  logic [15:0]    mispred_count;
`endif

  branch_flow_ctrl #(
    .PCW           (PCW),
    .QDEPTH        (2),
    .REFILL_CYCLES (2)
  ) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .BranchExists_ID   (branch_exists_id),
    .PCNow_ID          (pc_now_id),
    .BranchExists_EX   (branch_exists_ex),
    .PCNow_EX          (pc_now_ex),
    .BranchDecision_EX (branch_decision_ex),
    .BranchTarget_EX   (branch_target_ex),
    .Predicted_EX      (predicted_ex),
    .PredTarget_EX     (pred_target_ex),
    .LookupReq         (lookup_req),
    .LookupPC          (lookup_pc),
    .UpdateReq         (update_req),
    .UpdatePC          (update_pc),
    .UpdateTaken       (update_taken),
    .UpdateTarget      (update_target),
    .StallID           (stall_id),
    .FlushIFID         (flush_ifid),
    .FlushIDEX         (flush_idex),
    .Redirect          (redirect),
    .RedirectPC        (redirect_pc),
`ifdef BRANCH_FLOW_STATS_EN
    .BranchCount       (branch_count),
    .MispredCount      (mispred_count),
`endif
    .DbgState          (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [2*PCW:0] exp_q[$];        // {pc, taken, target}
  logic [PCW-1:0] exp_redir_q[$];

  task automatic chk(input string name, input logic [2*PCW:0] act, input logic [2*PCW:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes expected entries whenever the DUT presents them.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (update_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL upd_unexpected: got pc 0x%0h expected no update", update_pc);
        end else begin
          chk("upd_payload", {update_pc, update_taken, update_target}, exp_q.pop_front());
        end
      end
      if (redirect) begin
        if (exp_redir_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL redir_unexpected: got pc 0x%0h expected no redirect", redirect_pc);
        end else begin
          chk("redirect_pc", {33'd0, redirect_pc}, {33'd0, exp_redir_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic id, input logic [PCW-1:0] pid,
                       input logic ex, input logic [PCW-1:0] pex, input logic dec,
                       input logic [PCW-1:0] tgt, input logic pred, input logic [PCW-1:0] ptgt);
    @(posedge Clock);
    #1;
    branch_exists_id   = id;
    pc_now_id          = pid;
    branch_exists_ex   = ex;
    pc_now_ex          = pex;
    branch_decision_ex = dec;
    branch_target_ex   = tgt;
    predicted_ex       = pred;
    pred_target_ex     = ptgt;
    if (ex) exp_q.push_back({pex, dec, tgt});
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Continuous-traffic expectations (queue fills after two pushes).
  logic [4:0] t4_stall  = 5'b11100;   // bit i = cycle i
  logic [4:0] t4_lookup = 5'b00011;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    branch_exists_id = 0; pc_now_id = '0; branch_exists_ex = 0; pc_now_ex = '0;
    branch_decision_ex = 0; branch_target_ex = '0; predicted_ex = 0; pred_target_ex = '0;

    // ---- reset state ----
    repeat (2) @(negedge Clock);
    chk("rst_lookup",   lookup_req, 0);
    chk("rst_update",   update_req, 0);
    chk("rst_stall",    stall_id, 0);
    chk("rst_flush",    {flush_ifid, flush_idex}, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_state",    dbg_state, ST_RUN);
    @(posedge Clock);
    #1 Reset = 0;

    // ---- T1: correct prediction, update issued next cycle ----
    drive(0, '0, 1, 32'h40, 1, 32'h80, 1, 32'h80);
    @(negedge Clock);
    chk("t1_no_upd_yet", update_req, 0);
    chk("t1_no_redirect", redirect, 0);
    idle();
    @(negedge Clock);
    chk("t1_upd_issued", update_req, 1);
    chk("t1_no_flush", {flush_ifid, flush_idex}, 0);

    // ---- T2: taken mispredict to 0x100 ----
    drive(1, 32'h10, 1, 32'h50, 1, 32'h100, 0, 32'h0);
    exp_redir_q.push_back(32'h100);
    @(negedge Clock);
    chk("t2_lookup", lookup_req, 1);
    chk("t2_lookup_pc", lookup_pc, 32'h10);
    chk("t2_upd_wait", update_req, 0);
    drive(1, 32'h14, 0, '0, 0, '0, 0, '0);          // FLUSH
    @(negedge Clock);
    chk("t2_flush", {flush_ifid, flush_idex}, 2'b11);
    chk("t2_redirect", redirect, 1);
    chk("t2_flush_lookup", lookup_req, 0);
    chk("t2_flush_stall", stall_id, 0);
    chk("t2_flush_upd", update_req, 1);
    for (int i = 0; i < 2; i++) begin                // REFILL
      drive(1, 32'h18, 0, '0, 0, '0, 0, '0);
      @(negedge Clock);
      chk("t2_refill_lookup", lookup_req, 0);
      chk("t2_refill_pulse", {flush_ifid, flush_idex, redirect}, 0);
      chk("t2_refill_stall", stall_id, 0);
    end
    drive(1, 32'h1c, 0, '0, 0, '0, 0, '0);
    @(negedge Clock);
    chk("t2_run_lookup", lookup_req, 1);

    // ---- T3: not-taken mispredict at top of address space wraps ----
    drive(0, '0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1234);
    exp_redir_q.push_back(32'h0000_0000);
    idle();
    @(negedge Clock);
    chk("t3_redirect", redirect, 1);
    repeat (3) idle();
    @(negedge Clock);
    chk("t3_back_to_run", dbg_state, ST_RUN);

    // ---- T4: ID and EX every cycle, queue fills ----
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h1000 + 32'(i * 4), 1, 32'h200 + 32'(i * 8), 1,
            32'h300 + 32'(i * 8), 1, 32'h300 + 32'(i * 8));
      @(negedge Clock);
      chk("t4_stall",  stall_id,   t4_stall[i]);
      chk("t4_lookup", lookup_req, t4_lookup[i]);
      chk("t4_update", update_req, t4_stall[i]);
    end
    repeat (2) idle();
    idle();
    @(negedge Clock);
    chk("t4_drained", update_req, 0);

    // ---- T5: second mispredict during REFILL is wrong-path ----
    drive(0, '0, 1, 32'h300, 1, 32'h400, 0, 32'h0);
    exp_redir_q.push_back(32'h400);
    idle();
    @(negedge Clock);
    chk("t5_redirect", redirect, 1);
    drive(0, '0, 1, 32'h500, 1, 32'h600, 0, 32'h0);
    @(negedge Clock);
    chk("t5_no_second_redirect", redirect, 0);
    idle();
    @(negedge Clock);
    chk("t5_refill_no_redirect", redirect, 0);
    chk("t5_wrong_path_upd", update_req, 1);
    idle();
    @(negedge Clock);
    chk("t5_run_no_redirect", redirect, 0);
    chk("t5_state_run", dbg_state, ST_RUN);

    // ---- T6: reset during FLUSH ----
    drive(1, 32'h20, 1, 32'h600, 1, 32'h610, 1, 32'h610);
    drive(1, 32'h24, 1, 32'h700, 0, 32'h0, 1, 32'h0);
    @(posedge Clock);
    #1;
    branch_exists_id = 0; branch_exists_ex = 0;
    #1;
    chk("t6_pre_redirect", redirect, 1);
    chk("t6_pre_redir_pc", redirect_pc, 32'h704);
    chk("t6_pre_upd", update_req, 1);
    Reset = 1;
    #1;
    chk("t6_rst_redirect", redirect, 0);
    chk("t6_rst_flush", {flush_ifid, flush_idex}, 0);
    chk("t6_rst_upd", update_req, 0);
    chk("t6_rst_redir_pc", redirect_pc, 0);
    chk("t6_rst_state", dbg_state, ST_RUN);
    exp_q.delete();
    exp_redir_q.delete();
    @(posedge Clock);
    #1 Reset = 0;
    drive(1, 32'h30, 0, '0, 0, '0, 0, '0);
    @(negedge Clock);
    chk("t6_after_lookup", lookup_req, 1);
    chk("t6_after_lookup_pc", lookup_pc, 32'h30);
    chk("t6_after_empty", update_req, 0);
    idle();
    @(negedge Clock);

    // ---- final report ----
    chk("end_upd_q_empty", exp_q.size(), 0);
    chk("end_redir_q_empty", exp_redir_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
